// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: stereo I2S / left-justified serialiser for a PCM5102-class DAC.
// Generates BCK/LRCK from clk, takes stereo samples through a one-frame
// holding buffer and mutes (with an underrun pulse) when no sample is ready.
// Optional build macro: I2S_DAC_UNDERRUN_CNT_EN adds the saturating
// underrun counter; without it underrun_cnt is tied to zero.
module i2s_dac_tx #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fmt,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                bck,
  output logic                lrck,
  output logic                din,
  output logic                frame,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int B_W   = $clog2(2*SLOT_W);
  localparam int K_W   = $clog2(SLOT_W);
  localparam int I_W   = $clog2(SAMPLE_W);

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_t;

  logic [DIV_W-1:0]    div;
  logic [B_W-1:0]      b, b_nx, pos;
  logic                fresh;     // first falling tick after reset starts a frame
  logic                fmt_q, fmt_e;
  logic                full, rst_d;
  stereo_t             buf_q, sh, cur;
  logic [SAMPLE_W-1:0] prev_r, prv, word;
  logic                tick, fall, fstart, xfer;
  logic                lrck_nx, din_nx;

  // Slot bit k (k=0 is MSB): sample bit SAMPLE_W-1-k, zero padding past the sample.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] w, input logic [K_W-1:0] k);
    logic [I_W-1:0] idx;
    idx      = '0;
    slot_bit = 1'b0;
    if (32'(k) < SAMPLE_W) begin
      idx      = I_W'(SAMPLE_W - 1 - 32'(k));
      slot_bit = w[idx];
    end
  endfunction

  assign tick    = (div == DIV_W'(CLK_DIV - 1));
  assign fall    = tick && bck;
  assign fstart  = fall && (fresh || b == B_W'(2*SLOT_W - 1));
  assign s_ready = !full && !rst_d;
  assign xfer    = s_valid && s_ready;

  // Next bit position and the lrck/din values to present there.
  always_comb begin
    b_nx    = fstart ? '0 : b + B_W'(1);
    cur     = fstart ? (full ? buf_q : '0) : sh;
    prv     = fstart ? sh.r : prev_r;
    fmt_e   = fstart ? fmt : fmt_q;
    pos     = '0;
    word    = '0;
    lrck_nx = 1'b0;
    if (fmt_e) begin
      lrck_nx = (b_nx >= B_W'(SLOT_W));
      pos     = lrck_nx ? b_nx - B_W'(SLOT_W) : b_nx;
      word    = lrck_nx ? cur.r : cur.l;
    end else begin
      // I2S: lrck leads data by one BCK; position 0 carries the previous
      // frame's right LSB slot bit, hence the separate right latch.
      lrck_nx = (b_nx >= B_W'(SLOT_W - 1)) && (b_nx != B_W'(2*SLOT_W - 1));
      if (b_nx == '0) begin
        pos  = B_W'(SLOT_W - 1);
        word = prv;
      end else begin
        pos = b_nx - B_W'(1);
        if (pos >= B_W'(SLOT_W)) begin
          pos  = pos - B_W'(SLOT_W);
          word = cur.r;
        end else begin
          word = cur.l;
        end
      end
    end
    din_nx = slot_bit(word, K_W'(pos));
  end

  // Clock divider, bit counter, serial outputs, buffer and frame loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= '0;
      bck      <= 1'b0;
      b        <= '0;
      fresh    <= 1'b1;
      fmt_q    <= 1'b0;
      full     <= 1'b0;
      rst_d    <= 1'b1;
      buf_q    <= '0;
      sh       <= '0;
      prev_r   <= '0;
      lrck     <= 1'b0;
      din      <= 1'b0;
      frame    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rst_d    <= 1'b0;
      div      <= tick ? '0 : div + DIV_W'(1);
      frame    <= fstart;
      underrun <= fstart && !full;
      if (tick) bck <= ~bck;
      if (fall) begin
        b    <= b_nx;
        lrck <= lrck_nx;
        din  <= din_nx;
      end
      if (fstart) begin
        fresh  <= 1'b0;
        fmt_q  <= fmt;
        sh     <= cur;
        prev_r <= sh.r;
        if (full) full <= 1'b0;
      end
      // xfer needs an empty buffer, so it never collides with the drain above.
      if (xfer) begin
        full  <= 1'b1;
        buf_q <= '{l: s_left, r: s_right};
      end
    end
  end

`ifdef I2S_DAC_UNDERRUN_CNT_EN
  logic [15:0] cnt_q;

  // Saturating underrun count, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                                    cnt_q <= '0;
    else if (fstart && !full && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign underrun_cnt = cnt_q;
`else
  assign underrun_cnt = 16'h0;
`endif

endmodule
